mxint_accumulator: RTL
======================

MXINT_ACCUMULATOR -- requirements
Module: mxint_accumulator

Interface
REQ-001 The block SHALL have parameter IN_MAN_WIDTH, default 8: signed input mantissa width.
REQ-002 The block SHALL have parameter IN_EXP_WIDTH, default 4: unsigned biased shared exponent width.
REQ-003 The block SHALL have parameter BLOCK_SIZE, default 4: mantissas per block.
REQ-004 The block SHALL have parameter IN_DEPTH, default 4 (>=1): blocks summed per output.
REQ-005 The block SHALL have derived localparam OUT_MAN_WIDTH = IN_MAN_WIDTH + $clog2(IN_DEPTH).
REQ-006 The block SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 The block SHALL have port mdata_in, input, signed IN_MAN_WIDTH x BLOCK_SIZE (unpacked): input mantissas.
REQ-009 The block SHALL have port edata_in, input, IN_EXP_WIDTH: input shared exponent.
REQ-010 The block SHALL have ports data_in_valid (input, 1) and data_in_ready (output, 1): input handshake.
REQ-011 The block SHALL have port mdata_out, output, signed OUT_MAN_WIDTH x BLOCK_SIZE (unpacked): accumulated, unnormalized mantissas for mxint_cast.
REQ-012 The block SHALL have port edata_out, output, IN_EXP_WIDTH: shared exponent of the result.
REQ-013 The block SHALL have ports data_out_valid (output, 1) and data_out_ready (input, 1): output handshake.

Function
REQ-014 A transfer SHALL occur only on a rising edge where valid and ready are both high.
REQ-015 The block SHALL use a two-state FSM: ACCUM (data_in_ready=1, data_out_valid=0) and OUTPUT (data_out_valid=1, data_in_ready=data_out_ready).
REQ-016 A counter (width $clog2(IN_DEPTH)+1) SHALL count accepted blocks; on the first block the accumulator SHALL load the sign-extended input mantissas and edata_in directly.
REQ-017 For a later block, when edata_in > acc exponent (unsigned compare), the accumulator SHALL shift right arithmetically by the difference, add the input, and take edata_in; otherwise the input SHALL shift right by (acc exponent - edata_in) before the add.
REQ-018 A right shift >= OUT_MAN_WIDTH SHALL yield 0 for non-negative and -1 for negative operands.
REQ-019 The adder SHALL be OUT_MAN_WIDTH wide; because alignment only ever shifts right, the sum SHALL never overflow and SHALL NOT be saturated.
REQ-020 When the counter reaches IN_DEPTH, the FSM SHALL enter OUTPUT on the same edge, and data_out_valid SHALL assert one cycle after the final input handshake.
REQ-021 In OUTPUT, mdata_out/edata_out SHALL hold stable while data_out_ready is low.
REQ-022 An output handshake with no input handshake SHALL return the FSM to ACCUM with count 0.
REQ-023 When the output and input handshakes coincide, the new block SHALL become the first block of the next sum, leaving the FSM in ACCUM with count 1, or in OUTPUT if IN_DEPTH=1.
REQ-024 With IN_DEPTH=1, every block SHALL pass through with 1-cycle latency and full throughput.
REQ-025 Outside OUTPUT, mdata_out and edata_out SHALL retain their last registered value.

Reset
REQ-026 Asserting rst SHALL immediately set the FSM to ACCUM, the counter to 0, data_out_valid to 0, and all mdata_out and edata_out to 0.
REQ-027 Asserting rst SHALL discard any partial sum.
REQ-028 After deassertion, data_in_ready SHALL be 1 on the first cycle.

Configuration
REQ-029 With macro MXINT_ACCUMULATOR_ROUND_EN defined, every alignment right shift by s>0 SHALL add 1<<(s-1) before shifting (round half up); shifts >= OUT_MAN_WIDTH follow REQ-018.
REQ-030 Without MXINT_ACCUMULATOR_ROUND_EN, alignment shifts SHALL truncate toward negative infinity.

Verification (IN_MAN_WIDTH=8, IN_EXP_WIDTH=4, BLOCK_SIZE=2)
REQ-031 With IN_DEPTH=4, feeding four blocks {10,-3} at exp 5 back-to-back SHALL produce out {40,-12}, exp 5, with valid one cycle after the 4th handshake.
REQ-032 With IN_DEPTH=2, feeding {6,-6}@3 then {1,1}@5 SHALL produce {2,-1}@5 without the macro, and {3,0}@5 with it.
REQ-033 With IN_DEPTH=2, feeding {-5,5}@15 then {-5,5}@0 SHALL produce {-6,5}@15 (shift of 15 exceeds the width).
REQ-034 Holding data_out_ready low for 3 cycles in OUTPUT SHALL keep data_in_ready=0 and the outputs unchanged; on release, a coincident input SHALL start a new sum (count 1).
REQ-035 Asserting rst after 2 of 4 blocks SHALL reset the outputs and valid asynchronously; 4 fresh blocks {1,1}@0 SHALL then yield {4,4}@0.

Source files
------------

// File: rtl/mxint_accumulator.sv
// Sums IN_DEPTH MXINT blocks by aligning the lower-exponent operand rightwards onto the larger exponent; define MXINT_ACCUMULATOR_ROUND_EN for round-half-up alignment.
// Latency: result valid 1 cycle after the final input handshake; backpressure: while a result is pending, data_in_ready follows data_out_ready.
module mxint_accumulator #(
   parameter int  IN_MAN_WIDTH  = 8,
   parameter int  IN_EXP_WIDTH  = 4,
   parameter int  BLOCK_SIZE    = 4,
   parameter int  IN_DEPTH      = 4,
   localparam int OUT_MAN_WIDTH = IN_MAN_WIDTH + $clog2(IN_DEPTH)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic signed [IN_MAN_WIDTH-1:0]  mdata_in [BLOCK_SIZE],
   input  logic        [IN_EXP_WIDTH-1:0]  edata_in,
   input  logic                            data_in_valid,
   output logic                            data_in_ready,
   output logic signed [OUT_MAN_WIDTH-1:0] mdata_out [BLOCK_SIZE],
   output logic        [IN_EXP_WIDTH-1:0]  edata_out,
   output logic                            data_out_valid,
   input  logic                            data_out_ready
);

   localparam int CNT_WIDTH = $clog2(IN_DEPTH) + 1;

   typedef enum logic {ACCUM = 1'b0, OUTPUT = 1'b1} state_t;

   state_t                          state_q, state_d;
   logic [CNT_WIDTH-1:0]            cnt_q, cnt_d;
   logic signed [OUT_MAN_WIDTH-1:0] acc_man_q [BLOCK_SIZE];
   logic signed [OUT_MAN_WIDTH-1:0] acc_man_d [BLOCK_SIZE];
   logic signed [OUT_MAN_WIDTH-1:0] out_man_q [BLOCK_SIZE];
   logic signed [OUT_MAN_WIDTH-1:0] out_man_d [BLOCK_SIZE];
   logic signed [OUT_MAN_WIDTH-1:0] sum [BLOCK_SIZE];
   logic [IN_EXP_WIDTH-1:0]         acc_exp_q, acc_exp_d, out_exp_q, out_exp_d, sum_exp;
   logic                            in_hs, out_hs, first_blk, in_newer;

   // Shifts past the full width collapse to the sign (0 or -1), rounding included.
   function automatic logic signed [OUT_MAN_WIDTH-1:0] align(
      input logic signed [OUT_MAN_WIDTH-1:0] x,
      input logic        [IN_EXP_WIDTH-1:0]  s
   );
      logic signed [OUT_MAN_WIDTH:0] ext;
      if (32'(s) >= OUT_MAN_WIDTH) return {OUT_MAN_WIDTH{x[OUT_MAN_WIDTH-1]}};
      ext = {x[OUT_MAN_WIDTH-1], x};
`ifdef MXINT_ACCUMULATOR_ROUND_EN
      if (s != '0) ext = ext + ((OUT_MAN_WIDTH+1)'(1) << (s - 1'b1));
`endif
      ext = ext >>> s;
      return ext[OUT_MAN_WIDTH-1:0];
   endfunction

   assign data_in_ready  = (state_q == ACCUM) || data_out_ready;
   assign data_out_valid = (state_q == OUTPUT);
   assign mdata_out      = out_man_q;
   assign edata_out      = out_exp_q;

   always_comb begin
      in_hs     = data_in_valid && data_in_ready;
      out_hs    = data_out_valid && data_out_ready;
      first_blk = (state_q == OUTPUT) || (cnt_q == '0);
      in_newer  = edata_in > acc_exp_q;
      sum_exp   = (first_blk || in_newer) ? edata_in : acc_exp_q;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
         if (first_blk)
            sum[i] = OUT_MAN_WIDTH'(mdata_in[i]);
         else if (in_newer)
            sum[i] = align(acc_man_q[i], edata_in - acc_exp_q) + OUT_MAN_WIDTH'(mdata_in[i]);
         else
            sum[i] = acc_man_q[i] + align(OUT_MAN_WIDTH'(mdata_in[i]), acc_exp_q - edata_in);
      end

      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_man_d = acc_man_q;
      acc_exp_d = acc_exp_q;
      out_man_d = out_man_q;
      out_exp_d = out_exp_q;

      // A block accepted alongside an output handshake restarts the sum.
      if (in_hs) begin
         cnt_d     = first_blk ? CNT_WIDTH'(1) : cnt_q + 1'b1;
         acc_man_d = sum;
         acc_exp_d = sum_exp;
         if (cnt_d == CNT_WIDTH'(IN_DEPTH)) begin
            state_d   = OUTPUT;
            out_man_d = sum;
            out_exp_d = sum_exp;
         end else begin
            state_d = ACCUM;
         end
      end else if (out_hs) begin
         state_d = ACCUM;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ACCUM;
         cnt_q     <= '0;
         acc_exp_q <= '0;
         out_exp_q <= '0;
         for (int i = 0; i < BLOCK_SIZE; i++) begin
            acc_man_q[i] <= '0;
            out_man_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_man_q <= acc_man_d;
         acc_exp_q <= acc_exp_d;
         out_man_q <= out_man_d;
         out_exp_q <= out_exp_d;
      end
   end

endmodule
